// File: rtl/chunk_host_serializer.sv
// Byte-serial host transmitter: streams one num_bits chunk LSB byte first over ready/valid.
// Optional trailing XOR checksum beat when CHUNK_CHECKSUM_EN is defined.
module chunk_host_serializer #(
  parameter int num_bits = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [num_bits-1:0] chunk_in,
  input  logic                chunk_load,
  input  logic                flush,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                busy,
  output logic                done_flag,
  output logic                load_drop
);

  localparam int NBYTES = num_bits / 8;
  localparam int IDXW   = $clog2(NBYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
`ifdef CHUNK_CHECKSUM_EN
  localparam logic [1:0] S_CSUM = 2'd2;
  logic [7:0] csum;
`endif

  logic [1:0]          state;
  logic [IDXW-1:0]     idx;
  logic [num_bits-1:0] shreg;
  logic                beat;
  logic                last;

  assign beat       = byte_valid && byte_ready;
  assign last       = (idx == IDXW'(NBYTES - 1));
  assign busy       = (state != S_IDLE);
  assign byte_valid = (state != S_IDLE);

  // Current byte always sits in the low lane of the shift register.
`ifdef CHUNK_CHECKSUM_EN
  assign byte_out = (state == S_CSUM) ? csum :
                    (state == S_SEND) ? shreg[7:0] : '0;
`else
  assign byte_out = (state == S_SEND) ? shreg[7:0] : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      shreg     <= '0;
      done_flag <= 1'b0;
      load_drop <= 1'b0;
`ifdef CHUNK_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      done_flag <= 1'b0;
      load_drop <= 1'b0;
      if (flush) begin
        // Abort wins over a pending beat and over a load request.
        state <= S_IDLE;
        idx   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (chunk_load) begin
              shreg <= chunk_in;
              idx   <= '0;
              state <= S_SEND;
`ifdef CHUNK_CHECKSUM_EN
              csum  <= '0;
`endif
            end
          end
          S_SEND: begin
            load_drop <= chunk_load;
            if (beat) begin
              shreg <= shreg >> 8;
`ifdef CHUNK_CHECKSUM_EN
              csum  <= csum ^ shreg[7:0];
`endif
              if (last) begin
                idx   <= '0;
`ifdef CHUNK_CHECKSUM_EN
                state <= S_CSUM;
`else
                state     <= S_IDLE;
                done_flag <= 1'b1;
`endif
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
`ifdef CHUNK_CHECKSUM_EN
          S_CSUM: begin
            load_drop <= chunk_load;
            if (beat) begin
              state     <= S_IDLE;
              done_flag <= 1'b1;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
